// File: rtl/duck_vga_timing.sv
`default_nettype none
// ============================================================================
// Module      : duck_vga_timing
// Description : 640x480 @ 60 Hz VGA timing generator (800 x 525 pixel clocks).
//               Produces registered sync, blank and frame-start strobes aligned
//               with the DrawX/DrawY coordinates they describe.
//               Optional macro DUCK_VGA_FRAME_CNT_EN adds an 8-bit completed-
//               frame counter; without it frame_count is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module duck_vga_timing (
  input  logic       vga_clk,
  input  logic       reset,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       sync,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam logic [9:0] H_MAX      = 10'd799;
  localparam logic [9:0] V_MAX      = 10'd524;
  localparam logic [9:0] H_VISIBLE  = 10'd640;
  localparam logic [9:0] V_VISIBLE  = 10'd480;
  localparam logic [9:0] HS_START   = 10'd656;
  localparam logic [9:0] HS_END     = 10'd751;
  localparam logic [9:0] VS_START   = 10'd490;
  localparam logic [9:0] VS_END     = 10'd491;

  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       blank_q, blank_d;
  logic       frame_start_q, frame_start_d;
  logic       line_end;
  logic       frame_end;

  // Next counter values, and output decode from those next values so each
  // registered strobe lands in the same cycle as the coordinates it describes.
  always_comb begin
    line_end  = (hc_q == H_MAX);
    frame_end = line_end && (vc_q == V_MAX);

    hc_d = line_end ? 10'd0 : hc_q + 10'd1;
    vc_d = vc_q;
    if (frame_end) begin
      vc_d = 10'd0;
    end else if (line_end) begin
      vc_d = vc_q + 10'd1;
    end

    hs_d          = !((hc_d >= HS_START) && (hc_d <= HS_END));
    vs_d          = !((vc_d >= VS_START) && (vc_d <= VS_END));
    blank_d       = (hc_d < H_VISIBLE) && (vc_d < V_VISIBLE);
    frame_start_d = (hc_d == H_MAX) && (vc_d == V_MAX);
  end

  // Timing state; reset forces the idle (0,0) position immediately.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hc_q          <= 10'd0;
      vc_q          <= 10'd0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef DUCK_VGA_FRAME_CNT_EN
  logic [7:0] frame_count_q, frame_count_d;

  // Count completed frames on the same edge the counters wrap to (0,0).
  always_comb begin
    frame_count_d = frame_count_q;
    if (frame_end) begin
      frame_count_d = frame_count_q + 8'd1;
    end
  end

  // Frame counter register, cleared asynchronously with the timing state.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      frame_count_q <= 8'd0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;
`else
  assign frame_count = 8'd0;
`endif

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign frame_start = frame_start_q;
  assign sync        = 1'b0;

endmodule
`default_nettype wire

// File: doc/duck_vga_timing.md
DUCK_VGA_TIMING -- requirements
Module: duck_vga_timing

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Ports SHALL be, in order:
- vga_clk  input  1  pixel clock, 25 MHz, all state on rising edge.
- reset  input  1  asynchronous, active-high.
- hs  output  1  horizontal sync, active low.
- vs  output  1  vertical sync, active low.
- blank  output  1  display enable: 1 = visible pixel, 0 = blanking.
- sync  output  1  composite sync, constant 0.
- DrawX  output  10  current pixel column, equals horizontal counter.
- DrawY  output  10  current pixel row, equals vertical counter.
- frame_start  output  1  single-cycle pulse on the last pixel clock of each frame.
- frame_count  output  8  completed-frame counter (see Configuration).

Function
REQ-003 The horizontal counter hc SHALL count 0..799, incrementing every vga_clk, and wrap 799 -> 0.
REQ-004 The vertical counter vc SHALL increment only in the cycle where hc = 799, count 0..524, and wrap 524 -> 0 when hc = 799 and vc = 524.
REQ-005 DrawX and DrawY SHALL be the registered hc and vc values, with no extra latency.
REQ-006 hs, vs, blank and frame_start SHALL be registered outputs aligned to the same cycle as the DrawX/DrawY they describe.
- Each is computed from the next-state counter values; there is no combinational path from counters to outputs.
REQ-007 hs SHALL be 0 exactly when DrawX is in 656..751 inclusive, and 1 otherwise.
REQ-008 vs SHALL be 0 exactly when DrawY is in 490..491 inclusive, and 1 otherwise.
REQ-009 blank SHALL be 1 exactly when DrawX < 640 and DrawY < 480, and 0 otherwise.
REQ-010 frame_start SHALL be 1 exactly in the cycle where DrawX = 799 and DrawY = 524, and 0 otherwise.
REQ-011 A frame SHALL be 420000 cycles; a line SHALL be 800 cycles.
REQ-012 sync SHALL be constant 0 in all states.
REQ-013 Counter arithmetic SHALL be 10-bit unsigned; no value outside the stated ranges SHALL ever appear on DrawX or DrawY.

Reset
REQ-014 While reset = 1, outputs SHALL hold: hc = vc = 0, DrawX = 0, DrawY = 0, hs = 1, vs = 1, blank = 1, frame_start = 0, frame_count = 0.
REQ-015 Reset assertion SHALL take effect immediately, without waiting for a clock edge.
- This applies mid-line or mid-frame; no partial sync pulse may continue after reset asserts.
REQ-016 The first rising edge after reset deassertion SHALL advance DrawX to 1, with DrawY unchanged at 0.

Configuration
REQ-017 The macro DUCK_VGA_FRAME_CNT_EN SHALL control the frame counter.
REQ-018 With DUCK_VGA_FRAME_CNT_EN defined:
- frame_count SHALL increment by 1 on the same edge where hc/vc wrap from (799,524) to (0,0).
- frame_count SHALL wrap 255 -> 0.
- frame_count drives the duck animation frame select.
REQ-019 With DUCK_VGA_FRAME_CNT_EN undefined, frame_count SHALL be constant 0 and no counter register SHALL be synthesized.
- All other behaviour SHALL be identical to the defined case.

Verification
REQ-020 Scenario: reset released, run 800 cycles -> DrawX goes 0..799 and back to 0; DrawY goes 0 -> 1 on the wrap edge.
REQ-021 Scenario: one line -> hs low for exactly 96 cycles (DrawX 656..751); blank high for exactly 640 cycles while DrawY < 480.
REQ-022 Scenario: one full frame (420000 cycles) -> vs low for exactly 1600 cycles (DrawY 490..491); frame_start high exactly once, at (799,524).
REQ-023 Scenario: macro defined, run 256 frames -> frame_count reads 1 after frame 1, 255 after frame 255, and 0 after frame 256.
REQ-024 Scenario: assert reset asynchronously at DrawX = 700, DrawY = 300 (inside hs pulse) -> hs returns to 1 and DrawX/DrawY to 0 before the next clock edge; frame_count = 0.
REQ-025 Scenario: macro undefined, run 3 frames -> frame_count stays 0 throughout; all other checks from REQ-020..REQ-022 pass unchanged.
